d_modmul_stream: RTL and testbench
==================================

Name: d_modmul_stream

Overview:
- Streaming Dilithium coefficient multiplier: accepts operand pairs a, b in [0, Dq) with valid/ready, forms the 46-bit product and returns (a*b) mod Dq on a valid/ready output.
- Instantiates the fixed-latency, non-stallable CSA reducer D_redu and wraps it with valid tracking, credit-based flow control and an output FIFO, so NTT/pointwise-multiply controllers can apply back-pressure.

Parameters:
- Dq, 8380417, Dilithium modulus; used for checking and package constant only.
- RED_LAT, 3, D_redu latency in clk edges from data_in to result.
- LAT, 1+RED_LAT, total edges from accept to FIFO write.
- FIFO_DEPTH, 8, output FIFO entries; must be >= LAT+1, power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- in_a  in  23  operand a, 0..Dq-1
- in_b  in  23  operand b, 0..Dq-1
- in_last  in  1  tag, carried unchanged to out_last
- out_valid  out  1  result valid (FIFO non-empty)
- out_ready  in  1  consumer accepts result
- out_data  out  23  (a*b) mod Dq
- out_last  out  1  tag of this result

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On the rst edge, clear the valid shift register, last shift register, FIFO pointers and count. After that edge: out_valid=0, out_data=0, out_last=0, in_ready=1. The product register and D_redu internals may hold garbage; valid=0 masks it.
- Accept: in_valid & in_ready at edge N.
- Edge N: prod_q <= {2'b0, in_a*in_b} (48 bits).
- D_redu consumes prod_q. Its result is valid after edge N+RED_LAT.
- Edge N+LAT: the FIFO writes {result, last}. out_valid rises in the cycle after edge N+LAT (4 cycles with defaults).
- Valid and last shift registers, length LAT, advance every cycle unconditionally. The pipeline never stalls.
- Credit rule: inflight = popcount(valid shift register); in_ready = (fifo_count + inflight) < FIFO_DEPTH.
  - in_ready is computed from registered state only.
  - A pop in the current cycle does not return credit until the next cycle (conservative).
- This guarantees no FIFO write when full. A write while full is a design error; the verification engineer asserts it never occurs.
- FIFO:
  - pop = out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data/out_last come from the head entry and are stable while out_valid & !out_ready.
- Throughput: with out_ready held at 1, the block sustains 1 result/cycle with in_ready constantly 1 (steady state count+inflight = LAT+1 <= FIFO_DEPTH).
- Order: results leave in accept order; no reordering.
- Operands >= Dq: result unspecified; the bench never drives them.
- Reset mid-stream: all in-flight and buffered results are discarded. The first out_valid after reset belongs to the first post-reset accept.

Decomposition:
- Shared package d_pkg: Dq=8380417, coefficient width 23, product width 48, RED_LAT=3.
- Sub-modules:
  - D_redu, used as is.
  - One natural sub-module d_sync_fifo (WIDTH=24, DEPTH=FIFO_DEPTH, rst synchronous), exposing count, push, pop and head.
- Top level holds the multiplier register, shift registers and credit logic.

Test Plan:
- Single op a=8380416, b=8380416 at edge N, out_ready=1 -> out_valid first high after edge N+4, out_data=1, out_last=in_last.
- Directed values -> results:
  - a=4194304, b=2 -> 8191.
  - a=1, b=8380416 -> 8380416.
  - a=0, b=5 -> 0.
  - a=8380416, b=2 -> 8380415.
- Back-to-back 64 random pairs, out_ready=1 -> in_ready never drops, 64 results in order, each equal to (a*b)%8380417, one per cycle.
- out_ready=0, in_valid=1 continuously:
  - Exactly 8 pairs accepted, then in_ready=0.
  - out_valid stays high, head stable.
  - Raising out_ready drains 8 in order; accepts resume one cycle after the first pop.
- Random in_valid/out_ready (50%), 1000 ops with in_last on every 256th -> scoreboard match, out_last set on matching results, FIFO count never exceeds 8.
- Assert rst for one cycle with 3 in flight and 5 buffered -> out_valid=0 the cycle after reset, none of the 8 old results ever appear; the next accepted pair a=3, b=3 returns 9.

Source files
------------

// File: rtl/d_pkg.sv
// Shared constants and types for the Dilithium coefficient multiplier stream.
package d_pkg;
  localparam int unsigned COEF_W     = 23;
  localparam int unsigned MUL_W      = 2 * COEF_W;
  localparam int unsigned PROD_W     = 48;
  localparam int unsigned RED_LAT    = 3;
  localparam int unsigned LAT        = 1 + RED_LAT;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_W     = COEF_W + 1;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;

  localparam coef_t DQ = 23'd8380417;

  // FIFO entry: reduced coefficient plus the stream tag travelling with it.
  typedef struct packed {
    coef_t data;
    logic  last;
  } res_t;
endpackage

// File: rtl/d_modmul_stream_if.sv
// Operand/result handshake bundle; master drives operands and consumes results.
interface d_modmul_stream_if;
  import d_pkg::*;

  logic  in_valid;
  logic  in_ready;
  coef_t in_a;
  coef_t in_b;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  coef_t out_data;
  logic  out_last;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/D_redu.sv
// Fixed-latency (3 edges), non-stallable reduction of a product below Dq^2 to [0, Dq).
// Uses 2^23 == 2^13 - 1 (mod Dq) to fold high bits down, then one conditional subtract.
module D_redu
  import d_pkg::*;
(
  input  logic  clk,
  input  prod_t data_in,
  output coef_t result
);
  logic [24:0] hi1;
  logic [38:0] s1_d, s1_q;
  logic [15:0] hi2;
  logic [29:0] f2;
  logic [6:0]  hi3;
  logic [23:0] s2_d, s2_q;
  logic        ge;
  coef_t       res_d, res_q;

  // Each fold is x_lo + x_hi*2^13 - x_hi; never negative since x_hi*2^13 >= x_hi.
  always_comb begin
    hi1   = data_in[47:23];
    s1_d  = {16'b0, data_in[22:0]} + {1'b0, hi1, 13'b0} - {14'b0, hi1};
    hi2   = s1_q[38:23];
    f2    = {7'b0, s1_q[22:0]} + {1'b0, hi2, 13'b0} - {14'b0, hi2};
    hi3   = f2[29:23];
    s2_d  = {1'b0, f2[22:0]} + {4'b0, hi3, 13'b0} - {17'b0, hi3};
    ge    = s2_q >= {1'b0, DQ};
    // s2_q < 2*Dq, so after one subtract the value fits in 23 bits.
    res_d = s2_q[22:0] - (ge ? DQ : '0);
  end

  always_ff @(posedge clk) begin
    s1_q  <= s1_d;
    s2_q  <= s2_d;
    res_q <= res_d;
  end

  assign result = res_q;
endmodule

// File: rtl/d_sync_fifo.sv
// Synchronous FIFO, synchronous active-high reset; head is the oldest entry.
// Caller guarantees no push when full and no pop when empty.
module d_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/d_modmul_stream.sv
// Streaming (a*b) mod Dq: accept -> FIFO write in LAT edges, result visible one cycle later.
// The pipeline never stalls; credit (fifo count + in-flight) gates in_ready so the FIFO cannot overflow.
module d_modmul_stream
  import d_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  d_modmul_stream_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned INF_W = $clog2(LAT + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [LAT-1:0]   valid_q, valid_d;
  logic [LAT-1:0]   last_q, last_d;
  prod_t            prod_q, prod_d;
  logic [MUL_W-1:0] mult;
  coef_t            redu_res;
  res_t             push_dat;
  res_t             fifo_head;
  logic [CNT_W-1:0] fifo_cnt;
  logic [INF_W-1:0] inflight;
  logic [SUM_W-1:0] credit_sum;
  logic             in_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic             out_valid;

  // Credit comes only from registered state; a pop frees a slot one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + INF_W'(valid_q[i]);
    end
    credit_sum = {1'b0, fifo_cnt} + SUM_W'(inflight);
    in_ready   = credit_sum < SUM_W'(FIFO_DEPTH);
  end

  always_comb begin
    accept  = bus.in_valid & in_ready;
    mult    = MUL_W'(bus.in_a) * MUL_W'(bus.in_b);
    prod_d  = accept ? {{(PROD_W-MUL_W){1'b0}}, mult} : prod_q;
    valid_d = {valid_q[LAT-2:0], accept};
    last_d  = {last_q[LAT-2:0], accept & bus.in_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
    prod_q <= prod_d;
  end

  D_redu u_redu (
    .clk     (clk),
    .data_in (prod_q),
    .result  (redu_res)
  );

  // The oldest shift-register stage lines up with the reducer output.
  assign push     = valid_q[LAT-1];
  assign push_dat = '{data: redu_res, last: last_q[LAT-1]};

  d_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdat_i  (push_dat),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign out_valid     = fifo_cnt != '0;
  assign pop           = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? fifo_head.data : '0;
  assign bus.out_last  = out_valid & fifo_head.last;
endmodule

// File: tb/tb_d_modmul_stream.sv
// Scoreboard bench for d_modmul_stream: expected results queued at accept, checked at pop.
module tb_d_modmul_stream;
  import d_pkg::*;

  logic clk;
  logic rst;

  d_modmul_stream_if bus_if ();

  d_modmul_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp     = 0;
  int          n_err     = 0;
  int          acc_cnt   = 0;
  int          pop_cnt   = 0;
  int          occ       = 0;
  int          last_seen = 0;
  logic [23:0] exp_q [$];
  logic        rnd_mode  = 1'b0;

  coef_t dir_a [4] = '{23'd4194304, 23'd1, 23'd0, 23'd8380416};
  coef_t dir_b [4] = '{23'd2, 23'd8380416, 23'd5, 23'd2};
  coef_t dir_e [4] = '{23'd8191, 23'd8380416, 23'd0, 23'd8380415};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic coef_t mulmod(input coef_t a, input coef_t b);
    longint p;
    p = longint'(a) * longint'(b);
    return coef_t'(p % 64'd8380417);
  endfunction

  function automatic coef_t rnd_coef();
    return coef_t'($urandom_range(0, 8380416));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) bus_if.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drop();
    bus_if.in_valid = 1'b0;
  endtask

  // Holds the pair until accepted; returns the number of cycles it took.
  task automatic send(input coef_t a, input coef_t b, input logic l, input coef_t e, output int waits);
    logic rdy;
    waits           = 0;
    rdy             = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_last  = l;
    while (!rdy && waits < 300) begin
      @(negedge clk);
      rdy = bus_if.in_ready;
      step();
      waits++;
    end
    chk("accepted", 32'(rdy), 32'd1);
    if (rdy) exp_q.push_back({e, l});
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] e;
    if (rst) begin
      exp_q.delete();
      occ = 0;
    end else begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus_if.out_data), 32'(e[23:1]));
          chk("out_last", 32'(bus_if.out_last), 32'(e[0]));
        end
        pop_cnt++;
        occ--;
        if (bus_if.out_last) last_seen++;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        acc_cnt++;
        occ++;
        chk("occupancy_le_depth", 32'(occ <= 8), 32'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    w;
    int    p0;
    int    a0;
    int    l0;
    coef_t a;
    coef_t b;
    logic [23:0] h;

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus_if.out_data),  32'd0);
    chk("rst_out_last",  32'(bus_if.out_last),  32'd0);
    chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    step();

    // Single op: out_valid first high in the cycle after accept edge + 4.
    send(23'd8380416, 23'd8380416, 1'b1, 23'd1, w);
    drop();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("latency_out_valid", 32'(bus_if.out_valid), 32'(k == 4));
    end
    step();
    repeat (4) step();

    for (int i = 0; i < 4; i++) begin
      send(dir_a[i], dir_b[i], 1'(i == 2), dir_e[i], w);
      drop();
      repeat (2) step();
    end
    repeat (10) step();

    // Back-to-back: one accept and one result per cycle.
    p0 = pop_cnt;
    for (int i = 0; i < 64; i++) begin
      a = rnd_coef();
      b = rnd_coef();
      send(a, b, 1'b0, mulmod(a, b), w);
      chk("b2b_accept_cycles", 32'(w), 32'd1);
    end
    drop();
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_pops_run", 32'(pop_cnt - p0), 32'd63);
    @(negedge clk);
    #1;
    chk("b2b_pops_total", 32'(pop_cnt - p0), 32'd64);
    step();
    repeat (5) step();

    // Consumer stalled: exactly FIFO_DEPTH accepts, then back-pressure.
    bus_if.out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      a = rnd_coef();
      b = rnd_coef();
      send(a, b, 1'b0, mulmod(a, b), w);
      chk("fill_accept_cycles", 32'(w), 32'd1);
    end
    a = rnd_coef();
    b = rnd_coef();
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_last  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      h = exp_q[0];
      chk("full_in_ready",  32'(bus_if.in_ready),  32'd0);
      chk("full_out_valid", 32'(bus_if.out_valid), 32'd1);
      chk("full_head_data", 32'(bus_if.out_data),  32'(h[23:1]));
      step();
    end
    chk("full_accept_count", 32'(acc_cnt - a0), 32'd8);
    bus_if.out_ready = 1'b1;
    send(a, b, 1'b0, mulmod(a, b), w);
    chk("resume_accept_cycles", 32'(w), 32'd2);
    drop();
    repeat (20) step();

    // Random handshakes on both sides.
    p0 = pop_cnt;
    l0 = last_seen;
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 1) == 1) begin
        drop();
        step();
      end
      a = rnd_coef();
      b = rnd_coef();
      send(a, b, 1'((i % 256) == 255), mulmod(a, b), w);
    end
    drop();
    rnd_mode = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (30) step();
    chk("rnd_pop_count",  32'(pop_cnt - p0),   32'd1000);
    chk("rnd_last_count", 32'(last_seen - l0), 32'd3);
    chk("rnd_drained",    32'(exp_q.size()),   32'd0);

    // Reset with 5 results buffered and 3 in flight.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = rnd_coef();
      b = rnd_coef();
      send(a, b, 1'b0, mulmod(a, b), w);
    end
    drop();
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      a = rnd_coef();
      b = rnd_coef();
      send(a, b, 1'b0, mulmod(a, b), w);
    end
    drop();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("post_rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    step();
    bus_if.out_ready = 1'b1;
    p0 = pop_cnt;
    send(23'd3, 23'd3, 1'b1, 23'd9, w);
    drop();
    repeat (20) step();
    chk("post_rst_pop_count", 32'(pop_cnt - p0), 32'd1);
    chk("final_drained",      32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
